// File: rtl/twiddle_sequencer_if.sv
// Handshake bundle between the FFT stage controller, the twiddle sequencer and the
// butterfly multiplier. The sequencer uses the master modport.
interface twiddle_sequencer_if #(
  parameter int unsigned N_LOG2  = 3,
  parameter int unsigned W_WIDTH = 16,
  parameter int unsigned STAGE_W = 4
);
  logic                      start;
  logic [STAGE_W-1:0]        stage;
  logic                      inverse;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [W_WIDTH-1:0] W_real;
  logic signed [W_WIDTH-1:0] W_imag;
  logic [N_LOG2-2:0]         bfly_idx;
  logic                      out_last;

  modport master (
    input  start, stage, inverse, out_ready,
    output busy, out_valid, W_real, W_imag, bfly_idx, out_last
  );

  modport slave (
    output start, stage, inverse, out_ready,
    input  busy, out_valid, W_real, W_imag, bfly_idx, out_last
  );
endinterface

// File: rtl/twiddle_sequencer.sv
// Streams one twiddle W_N^k per butterfly of a radix-2 DIT FFT stage, with optional
// conjugation for the inverse transform and valid/ready backpressure.
module twiddle_sequencer #(
  parameter int unsigned N_LOG2  = 3,
  parameter int unsigned W_WIDTH = 16,
  parameter int unsigned STAGE_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  twiddle_sequencer_if.master bus
);

  localparam int unsigned BW   = N_LOG2 - 1;
  localparam int unsigned Half = 1 << BW;
  localparam logic [BW-1:0] Ones = '1;
  localparam logic [BW-1:0] BMax = '1;

  if (N_LOG2 < 2 || N_LOG2 > 10) begin : g_bad_size
    $error("twiddle_sequencer: N_LOG2 out of range 2..10");
  end
  if ((1 << STAGE_W) <= N_LOG2 - 1) begin : g_bad_stage_w
    $error("twiddle_sequencer: STAGE_W too narrow for N_LOG2");
  end

  // Elaboration-time Taylor series; x < pi so 30 terms is far beyond W_WIDTH precision.
  function automatic logic signed [W_WIDTH-1:0] rom_val(int unsigned k, bit want_sin);
    real x, term, acc, v;
    int  r;
    x = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << N_LOG2);
    if (want_sin) begin
      term = x;
      acc  = x;
      for (int n = 1; n < 30; n++) begin
        term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
        acc  = acc + term;
      end
    end else begin
      term = 1.0;
      acc  = 1.0;
      for (int n = 1; n < 30; n++) begin
        term = -term * x * x / (real'(2 * n - 1) * real'(2 * n));
        acc  = acc + term;
      end
    end
    v = acc * real'(1 << (W_WIDTH - 2));
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(-v + 0.5);
    if (want_sin) r = -r;
    return W_WIDTH'(r);
  endfunction

  logic signed [W_WIDTH-1:0] rom_re [Half];
  logic signed [W_WIDTH-1:0] rom_im [Half];

  for (genvar g = 0; g < Half; g++) begin : g_rom
    localparam logic signed [W_WIDTH-1:0] ReVal = rom_val(g, 1'b0);
    localparam logic signed [W_WIDTH-1:0] ImVal = rom_val(g, 1'b1);
    assign rom_re[g] = ReVal;
    assign rom_im[g] = ImVal;
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                    state_q, state_d;
  logic [STAGE_W-1:0]        stage_q, stage_d;
  logic                      inv_q, inv_d;
  logic [BW-1:0]             b_q, b_d;
  logic                      all_q, all_d;
  logic                      valid_q, valid_d;
  logic signed [W_WIDTH-1:0] re_q, re_d;
  logic signed [W_WIDTH-1:0] im_q, im_d;
  logic [BW-1:0]             idx_q, idx_d;
  logic                      last_q, last_d;

  logic          load;
  logic          inv_sel;
  logic [BW-1:0] mask;
  logic [BW-1:0] k;

  // b_q is zero whenever idle, so k is 0 for the first load regardless of stage_q.
  always_comb begin
    mask = ~(Ones << stage_q);
    k    = (b_q & mask) << (STAGE_W'(BW) - stage_q);
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    inv_d   = inv_q;
    b_d     = b_q;
    all_d   = all_q;
    valid_d = valid_q;
    re_d    = re_q;
    im_d    = im_q;
    idx_d   = idx_q;
    last_d  = last_q;
    load    = 1'b0;
    inv_sel = inv_q;

    unique case (state_q)
      StIdle: begin
        inv_sel = bus.inverse;
        if (bus.start && (32'(bus.stage) < N_LOG2)) begin
          state_d = StRun;
          stage_d = bus.stage;
          inv_d   = bus.inverse;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (!valid_q || bus.out_ready) begin
          if (!all_q) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            re_d    = '0;
            im_d    = '0;
            idx_d   = '0;
            last_d  = 1'b0;
            all_d   = 1'b0;
            b_d     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      valid_d = 1'b1;
      re_d    = rom_re[k];
      im_d    = inv_sel ? -rom_im[k] : rom_im[k];
      idx_d   = b_q;
      last_d  = (b_q == BMax);
      all_d   = (b_q == BMax);
      b_d     = b_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stage_q <= '0;
      inv_q   <= 1'b0;
      b_q     <= '0;
      all_q   <= 1'b0;
      valid_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
      b_q     <= b_d;
      all_q   <= all_d;
      valid_q <= valid_d;
      re_q    <= re_d;
      im_q    <= im_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.out_valid = valid_q;
  assign bus.W_real    = re_q;
  assign bus.W_imag    = im_q;
  assign bus.bfly_idx  = idx_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Scoreboard bench for twiddle_sequencer at N=8, Q2.14 twiddles.
module tb_twiddle_sequencer;
  localparam int unsigned NL = 3;
  localparam int unsigned WW = 16;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twiddle_sequencer_if #(.N_LOG2(NL), .W_WIDTH(WW), .STAGE_W(SW)) bus ();

  twiddle_sequencer #(.N_LOG2(NL), .W_WIDTH(WW), .STAGE_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [1:0]         idx;
    logic               last;
  } beat_t;

  beat_t sb[$];
  beat_t cur, held, exp_b;
  bit    hold_chk = 1'b0;
  int    compared = 0;
  int    mismatched = 0;

  // Hand-computed forward twiddles per stage and butterfly.
  int exp_re [3][4] = '{'{16384, 16384, 16384, 16384},
                        '{16384, 0, 16384, 0},
                        '{16384, 11585, 0, -11585}};
  int exp_im [3][4] = '{'{0, 0, 0, 0},
                        '{0, -16384, 0, -16384},
                        '{0, -11585, -16384, -11585}};

  task automatic check(string name, longint act, longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_beat(string name, beat_t act, beat_t req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got (%0d,%0d) idx=%0d last=%0d, required (%0d,%0d) idx=%0d last=%0d",
               name, act.re, act.im, act.idx, act.last, req.re, req.im, req.idx, req.last);
    end
  endtask

  // Monitor: samples on the falling edge, pops on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      cur = {bus.W_real, bus.W_imag, bus.bfly_idx, bus.out_last};
      if (bus.out_valid) begin
        if (hold_chk) check_beat("hold", cur, held);
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected beat", 1, 0);
          end else begin
            exp_b = sb.pop_front();
            check_beat("beat", cur, exp_b);
          end
          hold_chk = 1'b0;
        end else begin
          held     = cur;
          hold_chk = 1'b1;
        end
      end else begin
        check("idle outputs zero", {bus.W_real, bus.W_imag, bus.out_last}, 0);
        hold_chk = 1'b0;
      end
    end
  end

  task automatic issue(int s, bit inv);
    beat_t e;
    for (int b = 0; b < 4; b++) begin
      e.re   = 16'(exp_re[s][b]);
      e.im   = inv ? 16'(-exp_im[s][b]) : 16'(exp_im[s][b]);
      e.idx  = 2'(b);
      e.last = (b == 3);
      sb.push_back(e);
    end
    bus.stage   = 4'(s);
    bus.inverse = inv;
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " completes"}, longint'(bus.busy == 1'b0 && sb.size() == 0), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    bus.start     = 1'b0;
    bus.stage     = '0;
    bus.inverse   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("reset busy", bus.busy, 0);
    check("reset valid", bus.out_valid, 0);
    check("reset last", bus.out_last, 0);
    check("reset W_real", bus.W_real, 0);
    check("reset W_imag", bus.W_imag, 0);
    check("reset bfly_idx", bus.bfly_idx, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stage 2 forward: latency and back-to-back streaming.
    issue(2, 1'b0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("stream valid", bus.out_valid, 1);
      check("stream idx", bus.bfly_idx, b);
      check("stream busy", bus.busy, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("done valid", bus.out_valid, 0);
    check("done busy", bus.busy, 0);
    @(posedge clk);
    #1;

    issue(1, 1'b0);
    wait_idle("stage1");
    issue(0, 1'b1);
    wait_idle("stage0 inverse");
    issue(2, 1'b1);
    wait_idle("stage2 inverse");

    // Backpressure on bfly_idx=1 for three cycles.
    issue(2, 1'b0);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("stall idx", bus.bfly_idx, 1);
    check("stall valid", bus.out_valid, 1);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle("backpressure");

    // Start while busy must not disturb the running stage.
    issue(2, 1'b0);
    @(posedge clk);
    #1;
    bus.stage   = 4'd1;
    bus.inverse = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle("start while busy");

    // Out-of-range stage is ignored.
    bus.stage = 4'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("bad stage busy", bus.busy, 0);
    check("bad stage valid", bus.out_valid, 0);
    repeat (2) @(negedge clk);
    check("bad stage still idle", bus.busy, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset at bfly_idx=2, then a clean restart.
    issue(2, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (bus.out_valid && bus.bfly_idx == 2'd2) found = 1'b1;
    end
    check("reached idx 2", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst valid", bus.out_valid, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst W_real", bus.W_real, 0);
    check("async rst W_imag", bus.W_imag, 0);
    check("async rst idx", bus.bfly_idx, 0);
    check("async rst last", bus.out_last, 0);
    sb.delete();
    hold_chk = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2, 1'b0);
    @(negedge clk);
    check("restart valid", bus.out_valid, 1);
    check("restart idx", bus.bfly_idx, 0);
    wait_idle("restart");

    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/twiddle_sequencer.md
Name: twiddle_sequencer

Overview:
- Parametrised twiddle-factor generator for an N-point radix-2 DIT FFT, N = 2^N_LOG2.
- On a start pulse it streams one twiddle W_N^k per butterfly for the selected stage, in butterfly order.
- Supports forward mode and inverse (conjugate) mode, with valid/ready backpressure toward the butterfly datapath.
- Sits between the FFT stage controller and the butterfly multiplier; it replaces fixed per-size hard-coded count/case twiddle logic.

Parameters:
- N_LOG2, 3, log2 of FFT size; legal range 2..10.
- W_WIDTH, 16, signed twiddle width. Format is Q2.(W_WIDTH-2), so 1.0 = 2^(W_WIDTH-2).
- STAGE_W, 4, width of the stage select; must satisfy 2^STAGE_W > N_LOG2-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a stage sequence.
- stage  in  STAGE_W  stage number s, 0..N_LOG2-1, sampled with start.
- inverse  in  1  1 = conjugate twiddles (IFFT), sampled with start.
- busy  out  1  high from the accepted start until the last twiddle is accepted.
- out_valid  out  1  twiddle on W_real/W_imag is valid.
- out_ready  in  1  consumer accepts the twiddle when out_valid && out_ready.
- W_real  out  W_WIDTH  signed real part.
- W_imag  out  W_WIDTH  signed imaginary part.
- bfly_idx  out  N_LOG2-1  butterfly index b of the current twiddle.
- out_last  out  1  high with the final twiddle (b = N/2-1) of the stage.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, out_valid=0, out_last=0; W_real=W_imag=0; bfly_idx=0.
- ROM: N/2 entries, k = 0..N/2-1. real[k] = round(cos(2πk/N)·2^(W_WIDTH-2)); imag[k] = -round(sin(2πk/N)·2^(W_WIDTH-2)). Contents come from a synthesizable constant function; no file I/O.
- Twiddle index for stage s, butterfly b: k = (b mod 2^s) << (N_LOG2-1-s).
- Inverse mode: output imag = -ROM imag. Real part unchanged.
- States:
  - IDLE: start=1 with stage < N_LOG2 latches stage and inverse, sets busy=1, b=0, goes to RUN.
  - IDLE with start=1 and stage >= N_LOG2: start is ignored, no state change.
  - RUN: a registered output slot loads twiddle(b) whenever (!out_valid || out_ready), then b increments.
  - RUN exit: after the slot loads b = N/2-1, no further loads occur. When that twiddle is accepted, out_valid=0, busy=0, next state IDLE.
- Latency: the first out_valid rises exactly 1 cycle after the accepted start (ROM read is registered). With out_ready held high, one twiddle is produced per cycle, N/2 consecutive cycles, with no bubbles.
- Backpressure: while out_valid && !out_ready, W_real, W_imag, bfly_idx and out_last hold stable and b does not advance.
- When out_valid=0, W_real and W_imag are driven to 0.
- start while busy=1 is ignored. No queuing, and the latched stage/inverse values are unaffected.
- out_last=1 only together with out_valid=1 and bfly_idx = N/2-1.
- Stage 0: all twiddles are W^0 = (2^(W_WIDTH-2), 0).
- Last stage (s = N_LOG2-1): k = b.
- Reset mid-sequence: outputs return to reset values immediately (asynchronously) and the sequence is abandoned. The next start begins cleanly at b=0.
- No arithmetic overflow: 2^(W_WIDTH-2) fits in W_WIDTH signed bits.
- Negating any ROM value is safe because the most negative code is never stored.

Test Plan:
1. Reset and first stage: N_LOG2=3; reset, then start with stage=2, inverse=0, out_ready=1.
   - out_valid rises 1 cycle after start.
   - 4 consecutive twiddles: (16384,0), (11585,-11585), (0,-16384), (-11585,-11585).
   - bfly_idx = 0..3; out_last high on bfly_idx=3; busy drops after acceptance.
2. Stage 1: start with stage=1.
   - Twiddles: (16384,0), (0,-16384), (16384,0), (0,-16384).
3. Stage 0 with inverse=1:
   - Four times (16384,0); imag is never negative-zero and stays 0.
4. Inverse, stage 2:
   - Imag signs flip: (11585,11585), (0,16384), (-11585,11585).
5. Backpressure: stage 2, out_ready low for 3 cycles while bfly_idx=1.
   - (11585,-11585) holds stable throughout.
   - After out_ready rises, the sequence resumes in order with no skipped or duplicated index.
6. Ignored starts and reset:
   - start pulsed while busy: no effect on the sequence.
   - start with stage=3: no effect, remains IDLE.
   - rst_n asserted at bfly_idx=2: all outputs 0 asynchronously; a following start of stage=2 begins at bfly_idx=0.
